pucch1_spread_ctrl: RTL and testbench
=====================================

PUCCH1_SPREAD_CTRL -- requirements
Module: pucch1_spread_ctrl

Interface
REQ-001 The block SHALL have the following parameter: MAX_NSYM, default 14, maximum PUCCH symbol count accepted.
REQ-002 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  reset, asynchronous and active-high.
- i_start  input  1  one-cycle request to spread one PUCCH format 1 allocation.
- i_nsym  input  4  PUCCH symbol count, legal 4..MAX_NSYM.
- i_hop  input  1  intra-slot frequency hopping enabled.
- i_occi  input  3  orthogonal cover code index.
- sp_start  output  1  start pulse to the spreader.
- sp_next  output  1  request-next-element to the spreader.
- sp_nSF  output  3  spreading factor for the current hop.
- sp_occi  output  3  OCC index to the spreader.
- sp_wi_phi  input  4  spreader phase output.
- sp_valid  input  1  spreader output valid.
- sp_done  input  1  spreader sequence finished (informational only).
- o_wi_phi  output  4  forwarded phase.
- o_hop  output  1  hop index of o_wi_phi (0/1).
- o_m  output  3  element index within the hop, 0..nSF-1.
- o_valid  output  1  o_wi_phi/o_hop/o_m valid.
- o_busy  output  1  allocation in progress.
- o_done  output  1  one-cycle pulse after the last element of the last hop.
- o_err  output  1  one-cycle pulse on a rejected request.

Function
REQ-003 The block SHALL compute nSF as: no hopping, nSF0 = floor(nsym/2) and a single hop; hopping, nSF0 = floor(nsym/4) and nSF1 = floor(nsym/2) - floor(nsym/4).
REQ-004 The block SHALL, for a request, reject it with o_err pulsed one cycle after i_start when i_nsym < 4, i_nsym > MAX_NSYM, or i_occi >= min(nSF of all active hops), with no sp_start issued and o_busy never raised.
REQ-005 The block SHALL implement states IDLE -> CHECK -> HSTART -> RUN -> (HSTART for hop 1 | FIN) -> IDLE.
REQ-006 The block SHALL latch i_nsym, i_hop and i_occi in IDLE on i_start.
REQ-007 The block SHALL ignore i_start while o_busy=1 or in CHECK.
REQ-008 In HSTART, the block SHALL drive sp_start=1 for exactly one cycle, with sp_nSF set to the current hop's nSF and sp_occi set to the latched occi.
REQ-009 The block SHALL hold sp_nSF and sp_occi stable from HSTART through the end of RUN.
REQ-010 In RUN, the block SHALL hold sp_next=1 until the issued count reaches nSF, then deassert it; the issued count SHALL be counted per cycle of sp_next=1.
REQ-011 The block SHALL count received sp_valid beats, independent of spreader latency; the hop SHALL end on the cycle the received count reaches nSF.
REQ-012 The block SHALL drive o_wi_phi, o_valid and o_m as sp_wi_phi, sp_valid and the received count, registered with 1-cycle latency; o_hop SHALL be the current hop index.
REQ-013 The block SHALL go from the end of hop 0 to HSTART for hop 1 on the next cycle, with no idle gap beyond that single cycle.
REQ-014 The block SHALL assert o_done exactly once per accepted allocation, one cycle after the last o_valid beat; o_busy SHALL deassert in that same cycle.
REQ-015 The block SHALL ignore sp_valid received in IDLE, CHECK or HSTART, and SHALL NOT count it.
REQ-016 The block SHALL ignore sp_done for sequencing.
REQ-017 The total number of o_valid beats per allocation SHALL equal floor(nsym/2).

Reset
REQ-018 While rst=1, all outputs and counters SHALL be 0 and the state SHALL be IDLE, including when rst is asserted mid-allocation; an aborted allocation SHALL produce no o_done.
REQ-019 After rst deasserts, the first accepted i_start SHALL behave identically to one issued after power-up.

Configuration
REQ-020 With PUCCH1_CTRL_HOP_EN defined, i_hop SHALL select two-hop operation per REQ-003.
REQ-021 Without PUCCH1_CTRL_HOP_EN, i_hop SHALL be ignored, nSF0 = floor(nsym/2) always, o_hop SHALL be tied to 0, and the hop-1 path SHALL be removed.

Verification
REQ-022 nsym=14, hop=0, occi=3 -> one sp_start with sp_nSF=7; 7 o_valid beats with o_m 0..6 and o_hop=0; then o_done.
REQ-023 nsym=14, hop=1, occi=2 -> sp_start with sp_nSF=3, 3 beats with o_hop=0; then sp_start with sp_nSF=4, 4 beats with o_hop=1; then o_done.
REQ-024 nsym=6, hop=1, occi=1 -> o_err pulse (min nSF=1), no sp_start; nsym=3, hop=0 -> o_err.
REQ-025 nsym=8, hop=0, with the spreader model delaying sp_valid by 3 cycles -> 4 beats, o_done one cycle after the 4th; a second i_start issued mid-run is ignored.
REQ-026 rst asserted mid hop 1 -> all outputs 0 the next cycle and no o_done; the next request with nsym=4, hop=0, occi=0 completes with 2 beats.

Source files
------------

// File: rtl/pucch1_spread_ctrl_if.sv
// Spreader-side bus of the PUCCH format 1 spreading controller.
// master: controller (drives start/next/nSF/occi), slave: spreader.
interface pucch1_spread_ctrl_if;
    logic       sp_start;
    logic       sp_next;
    logic [2:0] sp_nSF;
    logic [2:0] sp_occi;
    logic [3:0] sp_wi_phi;
    logic       sp_valid;
    logic       sp_done;

    modport master (
        output sp_start, sp_next, sp_nSF, sp_occi,
        input  sp_wi_phi, sp_valid, sp_done
    );

    modport slave (
        input  sp_start, sp_next, sp_nSF, sp_occi,
        output sp_wi_phi, sp_valid, sp_done
    );
endinterface

// File: rtl/pucch1_spread_ctrl.sv
// PUCCH format 1 spreading controller.
// Validates a request, then runs one or two hops on the spreader: a one-cycle
// start per hop, sp_next until nSF elements are requested, and forwards
// nSF received phase beats per hop with one cycle of latency.
// Build option: define PUCCH1_CTRL_HOP_EN to enable intra-slot hopping
// (two hops); otherwise i_hop is ignored and only hop 0 exists.
module pucch1_spread_ctrl #(
    parameter int unsigned MAX_NSYM = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [3:0]            i_nsym,
    input  logic                  i_hop,
    input  logic [2:0]            i_occi,
    pucch1_spread_ctrl_if.master  sp,
    output logic [3:0]            o_wi_phi,
    output logic                  o_hop,
    output logic [2:0]            o_m,
    output logic                  o_valid,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_HSTART,
        S_RUN,
        S_FIN
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] nsym_q;
    logic [2:0] occi_q;
    logic [2:0] issued_q;
    logic [2:0] rcvd_q;
    logic [2:0] nsf0, nsf_min, nsf_cur;
    logic       req_bad;
    logic       beat_acc;
    logic       last_beat;
    logic       next_hop;
    logic       unused_sp_done;

    assign unused_sp_done = sp.sp_done;

    // Only beats arriving during RUN belong to the allocation.
    assign beat_acc  = (state_q == S_RUN) && sp.sp_valid;
    assign last_beat = beat_acc && ((rcvd_q + 3'd1) == nsf_cur);

`ifdef PUCCH1_CTRL_HOP_EN
    logic       hop_q;
    logic       cur_hop_q;
    logic [2:0] nsf1;

    assign nsf0     = hop_q ? 3'(nsym_q >> 2) : 3'(nsym_q >> 1);
    assign nsf1     = 3'(nsym_q >> 1) - 3'(nsym_q >> 2);
    assign nsf_min  = (hop_q && (nsf1 < nsf0)) ? nsf1 : nsf0;
    assign nsf_cur  = cur_hop_q ? nsf1 : nsf0;
    assign next_hop = hop_q && !cur_hop_q;

    // Hop mode latch, current hop index and the hop tag of each forwarded beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hop_q     <= 1'b0;
            cur_hop_q <= 1'b0;
            o_hop     <= 1'b0;
        end else begin
            if (state_q == S_IDLE && i_start) begin
                hop_q     <= i_hop;
                cur_hop_q <= 1'b0;
            end else if (last_beat && next_hop) begin
                cur_hop_q <= 1'b1;
            end
            if (beat_acc) begin
                o_hop <= cur_hop_q;
            end
        end
    end
`else
    logic unused_hop;

    assign unused_hop = i_hop;
    assign nsf0       = 3'(nsym_q >> 1);
    assign nsf_min    = nsf0;
    assign nsf_cur    = nsf0;
    assign next_hop   = 1'b0;
    assign o_hop      = 1'b0;
`endif

    assign req_bad = (nsym_q < 4'd4) || ({28'd0, nsym_q} > MAX_NSYM) || (occi_q >= nsf_min);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and spreader/status outputs.
    always_comb begin
        state_d     = state_q;
        sp.sp_start = 1'b0;
        sp.sp_next  = 1'b0;
        sp.sp_nSF   = '0;
        sp.sp_occi  = '0;
        o_busy      = 1'b0;
        o_err       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                o_err   = req_bad;
                state_d = req_bad ? S_IDLE : S_HSTART;
            end
            S_HSTART: begin
                sp.sp_start = 1'b1;
                sp.sp_nSF   = nsf_cur;
                sp.sp_occi  = occi_q;
                o_busy      = 1'b1;
                state_d     = S_RUN;
            end
            S_RUN: begin
                sp.sp_next = (issued_q < nsf_cur);
                sp.sp_nSF  = nsf_cur;
                sp.sp_occi = occi_q;
                o_busy     = 1'b1;
                if (last_beat) begin
                    state_d = next_hop ? S_HSTART : S_FIN;
                end
            end
            S_FIN: begin
                o_busy  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Request latch, per-hop issue/receive counters and registered beat outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nsym_q   <= '0;
            occi_q   <= '0;
            issued_q <= '0;
            rcvd_q   <= '0;
            o_wi_phi <= '0;
            o_m      <= '0;
            o_valid  <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            o_valid <= beat_acc;
            o_done  <= (state_q == S_FIN);
            if (beat_acc) begin
                o_wi_phi <= sp.sp_wi_phi;
                o_m      <= rcvd_q;
            end
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        nsym_q <= i_nsym;
                        occi_q <= i_occi;
                    end
                end
                S_HSTART: begin
                    issued_q <= '0;
                    rcvd_q   <= '0;
                end
                S_RUN: begin
                    if (sp.sp_next) begin
                        issued_q <= issued_q + 3'd1;
                    end
                    if (sp.sp_valid) begin
                        rcvd_q <= rcvd_q + 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pucch1_spread_ctrl.sv
// Bench for pucch1_spread_ctrl: spreader model with programmable latency,
// reference expectations derived from the nSF rules per request.
`timescale 1ns/1ps
module tb_pucch1_spread_ctrl;

    localparam int unsigned MAX_NSYM = 14;
`ifdef PUCCH1_CTRL_HOP_EN
    localparam bit HOP_EN = 1'b1;
`else
    localparam bit HOP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       i_start;
    logic [3:0] i_nsym;
    logic       i_hop;
    logic [2:0] i_occi;
    logic [3:0] o_wi_phi;
    logic       o_hop;
    logic [2:0] o_m;
    logic       o_valid;
    logic       o_busy;
    logic       o_done;
    logic       o_err;

    pucch1_spread_ctrl_if sp ();

    pucch1_spread_ctrl #(.MAX_NSYM(MAX_NSYM)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_start  (i_start),
        .i_nsym   (i_nsym),
        .i_hop    (i_hop),
        .i_occi   (i_occi),
        .sp       (sp),
        .o_wi_phi (o_wi_phi),
        .o_hop    (o_hop),
        .o_m      (o_m),
        .o_valid  (o_valid),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_err    (o_err)
    );

    always #5 clk = ~clk;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_miss++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [19:0] all_outs();
        return {o_wi_phi, o_hop, o_m, o_valid, o_busy, o_done, o_err,
                sp.sp_start, sp.sp_next, sp.sp_nSF, sp.sp_occi};
    endfunction

    // Spreader model: each sp_next cycle yields one phase beat spr_lat cycles later.
    int unsigned cyc = 0;
    int unsigned spr_lat = 1;
    bit          junk_valid = 1'b0;
    int unsigned due_q[$];
    logic [3:0]  pend_phi[$];
    logic [3:0]  exp_phi[$];

    always @(negedge clk) begin
        logic [3:0] ph;
        cyc++;
        sp.sp_done = 1'($urandom_range(0, 1));
        if (rst) begin
            due_q.delete();
            pend_phi.delete();
            sp.sp_valid  = 1'b0;
            sp.sp_wi_phi = '0;
        end else begin
            if (due_q.size() != 0 && due_q[0] == cyc) begin
                sp.sp_valid  = 1'b1;
                sp.sp_wi_phi = pend_phi.pop_front();
                void'(due_q.pop_front());
            end else begin
                sp.sp_valid  = junk_valid;
                sp.sp_wi_phi = 4'($urandom);
            end
            if (sp.sp_next === 1'b1) begin
                ph = 4'($urandom);
                due_q.push_back(cyc + spr_lat);
                pend_phi.push_back(ph);
                exp_phi.push_back(ph);
            end
        end
    end

    task automatic run_alloc(input int unsigned nsym, input bit hop, input int unsigned occi,
                             input int unsigned lat, input bit extra);
        bit          heff, bad, extra_done, drop_start;
        int unsigned nsf[2];
        int unsigned nhops, total, mn;
        int unsigned exp_hop[$];
        int unsigned exp_m[$];
        int unsigned k, starts, beats, nexts, dones, errs, last_k, hh, mm;
        logic [3:0]  ph;

        heff = hop && HOP_EN;
        if (heff) begin
            nsf[0] = nsym / 4;
            nsf[1] = nsym / 2 - nsym / 4;
            nhops  = 2;
            mn     = (nsf[1] < nsf[0]) ? nsf[1] : nsf[0];
        end else begin
            nsf[0] = nsym / 2;
            nsf[1] = 0;
            nhops  = 1;
            mn     = nsf[0];
        end
        total = nsym / 2;
        bad   = (nsym < 4) || (nsym > MAX_NSYM) || (occi >= mn);
        for (int unsigned h = 0; h < nhops; h++)
            for (int unsigned m = 0; m < nsf[h]; m++) begin
                exp_hop.push_back(h);
                exp_m.push_back(m);
            end

        spr_lat = lat;
        @(negedge clk);
        i_start = 1'b1;
        i_nsym  = 4'(nsym);
        i_hop   = hop;
        i_occi  = 3'(occi);
        @(negedge clk);
        i_start = 1'b0;
        i_nsym  = 4'($urandom);
        i_hop   = 1'($urandom);
        i_occi  = 3'($urandom);
        chk("err_pulse", o_err, bad);
        chk("busy_in_check", o_busy, 0);
        if (bad) begin
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                chk("reject_quiet", {sp.sp_start, o_busy, o_err, o_valid}, 0);
            end
            return;
        end

        k = 0; starts = 0; beats = 0; nexts = 0; dones = 0; errs = 0; last_k = 0;
        extra_done = 1'b0; drop_start = 1'b0;
        while (dones == 0 && k < 400) begin
            @(negedge clk);
            k++;
            if (drop_start) begin
                i_start    = 1'b0;
                drop_start = 1'b0;
            end
            if (o_err) errs++;
            if (sp.sp_start) begin
                if (starts < nhops) begin
                    chk("start_nSF", sp.sp_nSF, nsf[starts]);
                    chk("start_occi", sp.sp_occi, occi);
                    chk("busy_at_start", o_busy, 1);
                end
                if (starts == 1)
                    chk("hop_gap", {o_valid, o_m}, {1'b1, 3'(nsf[0] - 1)});
                starts++;
            end
            if (sp.sp_next) begin
                nexts++;
                if (starts > 0 && starts <= nhops)
                    chk("hold_nSF_occi", {sp.sp_nSF, sp.sp_occi}, {3'(nsf[starts - 1]), 3'(occi)});
            end
            if (o_valid) begin
                if (exp_m.size() == 0) begin
                    chk("beat_overflow", beats + 1, total);
                end else begin
                    hh = exp_hop.pop_front();
                    mm = exp_m.pop_front();
                    ph = (exp_phi.size() != 0) ? exp_phi.pop_front() : 4'd0;
                    chk("beat", {o_hop, o_m, o_wi_phi}, {1'(hh), 3'(mm), ph});
                end
                beats++;
                last_k = k;
                if (extra && !extra_done && beats == 1) begin
                    i_start    = 1'b1;
                    i_nsym     = 4'd4;
                    i_hop      = 1'b0;
                    i_occi     = 3'd0;
                    extra_done = 1'b1;
                    drop_start = 1'b1;
                end
            end
            if (o_done) begin
                dones++;
                chk("done_latency", k, last_k + 1);
                chk("busy_at_done", o_busy, 0);
            end
        end
        i_start = 1'b0;
        chk("done_seen", dones, 1);
        chk("beat_total", beats, total);
        chk("hop_starts", starts, nhops);
        chk("issued_total", nexts, total);
        chk("no_err_on_good", errs, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_idle", {o_done, o_valid, o_busy, sp.sp_start}, 0);
        end
    endtask

    initial begin
        rst     = 1'b1;
        i_start = 1'b0;
        i_nsym  = '0;
        i_hop   = 1'b0;
        i_occi  = '0;
        repeat (3) @(negedge clk);
        chk("reset_outs", all_outs(), 0);
        rst = 1'b0;

        // Stray spreader beats while idle must not surface.
        junk_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("idle_valid_ignored", {o_valid, o_busy}, 0);
        end
        junk_valid = 1'b0;
        @(negedge clk);
        chk("idle_valid_ignored", o_valid, 0);

        run_alloc(14, 1'b0, 3, 1, 1'b0);
        run_alloc(14, 1'b1, 2, 2, 1'b0);
        run_alloc(6,  1'b1, 1, 1, 1'b0);
        run_alloc(3,  1'b0, 0, 1, 1'b0);
        run_alloc(8,  1'b0, 0, 3, 1'b1);
        run_alloc(15, 1'b0, 0, 1, 1'b0);
        run_alloc(4,  1'b0, 2, 1, 1'b0);
        run_alloc(4,  1'b0, 1, 2, 1'b0);

        // Abort mid-run by reset.
        begin : abort_seq
            int unsigned seen, w;
            seen = 0;
            w    = 0;
            spr_lat = 2;
            @(negedge clk);
            i_start = 1'b1;
            i_nsym  = 4'd14;
            i_hop   = 1'b1;
            i_occi  = 3'd0;
            @(negedge clk);
            i_start = 1'b0;
            while (seen < 4 && w < 200) begin
                @(negedge clk);
                w++;
                if (o_valid) seen++;
            end
            chk("pre_abort_beats", seen, 4);
            rst = 1'b1;
            #1;
            chk("abort_outs_zero", all_outs(), 0);
            @(negedge clk);
            chk("abort_outs_held", all_outs(), 0);
            rst = 1'b0;
            exp_phi.delete();
            repeat (6) begin
                @(negedge clk);
                chk("no_done_after_abort", {o_done, o_busy, o_valid}, 0);
            end
        end
        run_alloc(4, 1'b0, 0, 1, 1'b0);

        for (int unsigned r = 0; r < 20; r++)
            run_alloc($urandom_range(0, 15), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                      $urandom_range(1, 4), 1'($urandom_range(0, 1)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
